// File: rtl/wb_reg_master.sv
// Single-outstanding Wishbone classic register master: one command in, one bus
// cycle out, one response back, with a wait-cycle timeout that aborts stuck cycles.
module wb_reg_master #(
    parameter int ADR_WIDTH = 14,
    parameter int TIMEOUT   = 64
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADR_WIDTH-1:0] cmd_adr,
    input  logic [31:0]          cmd_dat,
    input  logic [3:0]           cmd_sel,
    input  logic                 cmd_we,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_dat,
    output logic                 rsp_err,
    output logic [ADR_WIDTH-1:0] bus_adr,
    output logic [31:0]          bus_dat_w,
    output logic [3:0]           bus_sel,
    output logic                 bus_we,
    output logic                 bus_cyc,
    output logic                 bus_stb,
    input  logic [31:0]          bus_dat_r,
    input  logic                 bus_ack
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          accept, ack_hit, timeout_hit, rsp_take;

    assign cmd_ready = (state == IDLE) && !sys_rst;
    assign bus_stb   = bus_cyc;

    always_comb begin
        state_nxt   = state;
        accept      = cmd_valid && cmd_ready;
        ack_hit     = (state == BUS) && bus_ack;
        // ack takes priority over an expiring counter in the same cycle
        timeout_hit = (state == BUS) && !bus_ack && (wait_cnt == CW'(TIMEOUT - 1));
        rsp_take    = (state == RESP) && rsp_ready;
        case (state)
            IDLE:    if (accept) state_nxt = BUS;
            BUS:     if (ack_hit || timeout_hit) state_nxt = RESP;
            RESP:    if (rsp_take) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bus_adr   <= '0;
            bus_dat_w <= '0;
            bus_sel   <= '0;
            bus_we    <= 1'b0;
            bus_cyc   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            if (accept) begin
                bus_adr   <= cmd_adr;
                bus_dat_w <= cmd_dat;
                bus_sel   <= cmd_sel;
                bus_we    <= cmd_we;
                bus_cyc   <= 1'b1;
                wait_cnt  <= '0;
            end
            if (ack_hit) begin
                bus_cyc   <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_dat   <= bus_we ? 32'h0 : bus_dat_r;
                rsp_err   <= 1'b0;
            end else if (timeout_hit) begin
                bus_cyc   <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_dat   <= 32'h0;
                rsp_err   <= 1'b1;
            end else if (state == BUS) begin
                wait_cnt  <= wait_cnt + CW'(1);
            end
            if (rsp_take) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_reg_master.sv
// Directed table-driven bench for wb_reg_master with a cycle-counting slave model.
module tb_wb_reg_master;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        cmd_valid, cmd_ready;
    logic [13:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        cmd_we;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic [13:0] bus_adr;
    logic [31:0] bus_dat_w;
    logic [3:0]  bus_sel;
    logic        bus_we, bus_cyc, bus_stb;
    logic [31:0] bus_dat_r;
    logic        bus_ack;

    int total = 0;
    int bad   = 0;

    always #5 sys_clk = ~sys_clk;

    wb_reg_master #(.ADR_WIDTH(14), .TIMEOUT(64)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr),
        .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_we(cmd_we),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .bus_adr(bus_adr), .bus_dat_w(bus_dat_w), .bus_sel(bus_sel), .bus_we(bus_we),
        .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_dat_r(bus_dat_r), .bus_ack(bus_ack)
    );

    typedef struct {
        logic        we;
        logic [13:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          ack_dly;   // -1: slave never acks
        logic [31:0] rdat;
        int          hold;      // cycles rsp_ready stays low
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        int n;
        cmd_valid = 1'b1;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        cmd_sel   = v.sel;
        cmd_we    = v.we;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (bus_cyc && n < 200) begin
            chk("bus_adr", 32'(bus_adr), 32'(v.adr));
            chk("bus_dat_w", bus_dat_w, v.dat);
            chk("bus_sel", 32'(bus_sel), 32'(v.sel));
            chk("bus_we", 32'(bus_we), 32'(v.we));
            chk("bus_stb", 32'(bus_stb), 32'd1);
            chk("cmd_ready_bus", 32'(cmd_ready), 32'd0);
            bus_ack   = (n == v.ack_dly);
            bus_dat_r = (n == v.ack_dly) ? v.rdat : 32'hA5A5A5A5;
            step();
            n++;
        end
        bus_ack = 1'b0;
        chk("cyc_cycles", 32'(n), 32'(v.exp_cyc));
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_dat", rsp_dat, v.exp_dat);
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        // stray acks and a pending new command while the response waits
        for (int h = 0; h < v.hold; h++) begin
            cmd_valid = 1'b1;
            bus_ack   = 1'b1;
            bus_dat_r = 32'hFFFFFFFF;
            step();
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_dat", rsp_dat, v.exp_dat);
            chk("hold_rsp_err", 32'(rsp_err), 32'(v.exp_err));
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold_cyc", 32'(bus_cyc), 32'd0);
        end
        cmd_valid = 1'b0;
        bus_ack   = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
        chk("retain_adr", 32'(bus_adr), 32'(v.adr));
        chk("retain_cyc", 32'(bus_cyc), 32'd0);
    endtask

    initial begin
        //         we    adr       dat           sel   dly rdat          hold exp_dat       err  cyc
        vecs[0] = '{1'b1, 14'h0010, 32'hDEADBEEF, 4'hF, 0,  32'h0,        1,   32'h0,        1'b0, 1};
        vecs[1] = '{1'b0, 14'h0004, 32'h0,        4'hF, 3,  32'h12345678, 1,   32'h12345678, 1'b0, 4};
        vecs[2] = '{1'b0, 14'h0020, 32'h0,        4'hF, -1, 32'h0,        2,   32'h0,        1'b1, 64};
        vecs[3] = '{1'b0, 14'h3FFF, 32'h0,        4'hF, 63, 32'hCAFEF00D, 1,   32'hCAFEF00D, 1'b0, 64};
        vecs[4] = '{1'b1, 14'h0155, 32'h01020304, 4'h3, 5,  32'h55555555, 1,   32'h0,        1'b0, 6};
        vecs[5] = '{1'b0, 14'h0008, 32'h0,        4'h1, 0,  32'h0BADF00D, 5,   32'h0BADF00D, 1'b0, 1};
        vecs[6] = '{1'b0, 14'h0009, 32'h0,        4'h2, 1,  32'h77665544, 1,   32'h77665544, 1'b0, 2};

        sys_rst = 1'b1; cmd_valid = 1'b1; cmd_adr = 14'h1234; cmd_dat = 32'h11111111;
        cmd_sel = 4'hF; cmd_we = 1'b1; rsp_ready = 1'b0; bus_ack = 1'b0; bus_dat_r = '0;
        step(); step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_cyc", 32'(bus_cyc), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_bus_adr", 32'(bus_adr), 32'd0);
        chk("rst_bus_dat_w", bus_dat_w, 32'd0);
        chk("rst_bus_sel_we", 32'({bus_sel, bus_we}), 32'd0);
        chk("rst_rsp", {rsp_dat[30:0], rsp_err}, 32'd0);
        cmd_valid = 1'b0;
        sys_rst   = 1'b0;
        step();
        chk("post_rst_cyc", 32'(bus_cyc), 32'd0);

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // reset during the second BUS cycle aborts and drops the response
        cmd_valid = 1'b1; cmd_adr = 14'h0040; cmd_we = 1'b0; cmd_sel = 4'hF;
        step();
        cmd_valid = 1'b0;
        chk("abort_cyc_on", 32'(bus_cyc), 32'd1);
        step();
        chk("abort_cyc_2nd", 32'(bus_cyc), 32'd1);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        chk("abort_cyc_off", 32'(bus_cyc), 32'd0);
        chk("abort_adr_clr", 32'(bus_adr), 32'd0);
        for (int k = 0; k < 4; k++) begin
            bus_ack = 1'b1;
            step();
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
            chk("abort_no_cyc", 32'(bus_cyc), 32'd0);
        end
        bus_ack = 1'b0;
        run_txn(vecs[6]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_reg_master.md
WB_REG_MASTER -- requirements
Module: wb_reg_master

Interface
REQ-001 Parameter ADR_WIDTH, default 14, Wishbone word-address width.
REQ-002 Parameter TIMEOUT, default 64, maximum cycles in BUS before the cycle is aborted; legal range 2..65535.
REQ-003 sys_clk  input  1  single clock; all logic on its rising edge.
REQ-004 sys_rst  input  1  reset; synchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 cmd_adr  input  ADR_WIDTH  target word address.
REQ-008 cmd_dat  input  32  write data.
REQ-009 cmd_sel  input  4  byte lane selects.
REQ-010 cmd_we  input  1  1=write, 0=read.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-013 rsp_dat  output  32  read data; 0 for writes and errors.
REQ-014 rsp_err  output  1  1=timeout abort.
REQ-015 bus_adr, bus_dat_w, bus_sel, bus_we  outputs  ADR_WIDTH/32/4/1  Wishbone classic master request signals.
REQ-016 bus_cyc, bus_stb  outputs  1  cycle/strobe, always equal.
REQ-017 bus_dat_r  input  32; bus_ack  input  1  slave read data and acknowledge.

Function
REQ-018 FSM states IDLE, BUS, RESP; exactly one transaction outstanding.
REQ-019 cmd_ready SHALL be 1 only in IDLE and not in reset.
REQ-020 Accept (cmd_valid&cmd_ready at edge N): latch adr/dat/sel/we onto bus_* outputs, state=BUS; bus_cyc=bus_stb=1 from cycle N+1.
REQ-021 In BUS all bus_* request outputs SHALL be held stable; wait counter starts at 0 on entry and increments each cycle without ack.
REQ-022 bus_ack sampled high in BUS: cyc/stb low next cycle; rsp_dat=bus_dat_r if read else 0; rsp_err=0; state=RESP.
REQ-023 Counter reaching TIMEOUT-1 without ack: cyc/stb low next cycle; rsp_dat=0; rsp_err=1; state=RESP.
REQ-024 Ack and timeout in same cycle: ack wins, rsp_err=0.
REQ-025 bus_ack outside BUS SHALL be ignored with no state, counter or output change.
REQ-026 In RESP rsp_valid=1; rsp_dat/rsp_err held stable until rsp_ready; on handshake state=IDLE, rsp_valid=0 next cycle.
REQ-027 Zero-wait slave with rsp_ready tied high: accept N, cyc N+1, rsp_valid N+2, cmd_ready N+3; 3 cycles/transaction minimum.
REQ-028 bus_adr/bus_dat_w/bus_sel/bus_we retain last values after cycle ends; bus_dat_r ignored outside ack.
REQ-029 All outputs except cmd_ready SHALL be registered; counter width ceil(log2(TIMEOUT))+1, no wrap.

Reset
REQ-030 sys_rst high at edge: state=IDLE, bus_cyc=bus_stb=bus_we=0, bus_adr=bus_dat_w=bus_sel=0, rsp_valid=rsp_err=0, rsp_dat=0, counter=0.
REQ-031 Reset in BUS or RESP aborts immediately: cyc/stb low the cycle after the reset edge; pending response discarded, never presented.
REQ-032 cmd_valid during reset SHALL NOT be accepted.

Verification
REQ-033 Write adr=0x0010 dat=0xDEADBEEF sel=0xF, ack 1 cycle after cyc -> bus_we=1, dat_w=0xDEADBEEF during cyc; rsp_valid rsp_err=0 rsp_dat=0.
REQ-034 Read adr=0x0004, ack after 3 wait cycles with bus_dat_r=0x12345678 -> request stable 4 cycles; rsp_dat=0x12345678 rsp_err=0.
REQ-035 Read, no ack, TIMEOUT=64 -> cyc high exactly 64 cycles; rsp_err=1 rsp_dat=0; ack at cycle 64 later ignored.
REQ-036 Back-to-back commands, rsp_ready held low 5 cycles -> rsp_dat stable, cmd_ready=0, no second cyc until response taken.
REQ-037 sys_rst asserted 2nd cycle of BUS -> cyc=0 next cycle, rsp_valid never 1, next command completes normally.
REQ-038 Ack coincident with final timeout cycle -> rsp_err=0, read data returned.
